// File: rtl/nios_system_led_seq_pkg.sv
// Shared definitions for the LED sequencer: register offsets, CONTROL/STATUS
// bit positions and the sequencer state encoding.
package nios_system_led_seq_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_PERIOD   = 3'd3;
    localparam logic [2:0] ADDR_LENGTH   = 3'd4;
    localparam logic [2:0] ADDR_TBL_ADDR = 3'd5;
    localparam logic [2:0] ADDR_TBL_DATA = 3'd6;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_LOOP    = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 8;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/nios_system_led_seq_timer.sv
// 32-bit step timer: loads a value, counts down while enabled and parks at zero.
module nios_system_led_seq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 32'd0)) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 32'd0);

endmodule

// File: rtl/nios_system_led_sequencer.sv
// Avalon-MM LED sequencer: plain output register in IDLE, steps through a
// programmable pattern table at a programmable rate in RUN.
module nios_system_led_sequencer
    import nios_system_led_seq_pkg::*;
#(
    parameter int          WIDTH        = 9,
    parameter int          DEPTH        = 16,
    parameter logic [31:0] PERIOD_RESET = 32'd49_999_999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_ZERO = '0;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            done_q, done_d;
    logic [31:0]     period_q, period_d;
    logic [AW:0]     length_q, length_d;
    logic [AW-1:0]   tbl_addr_q, tbl_addr_d;
    logic [WIDTH-1:0] tbl_q [DEPTH];

    logic            wr, ctrl_wr, tbl_we, tmr_load, tmr_zero, last;
    logic [AW:0]     len_m1;
    logic [AW-1:0]   last_idx;
    logic [31:0]     rdata;

    assign wr       = chipselect & ~write_n;
    assign ctrl_wr  = wr && (address == ADDR_CONTROL);
    assign len_m1   = length_q - (AW+1)'(1);
    assign last_idx = len_m1[AW-1:0];
    // ">=" so a LENGTH shrunk below the current index ends at the next boundary
    assign last     = ({1'b0, idx_q} >= len_m1);

    nios_system_led_seq_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (period_q),
        .en       (state_q == ST_RUN),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_d      = out_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        done_d     = done_q;
        period_d   = period_q;
        length_d   = length_q;
        tbl_addr_d = tbl_addr_q;
        tbl_we     = 1'b0;
        tmr_load   = 1'b0;

        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = writedata[WIDTH-1:0];
                ADDR_CONTROL:  ctrl_d = writedata[2:0];
                ADDR_STATUS:   if (writedata[STAT_DONE]) done_d = 1'b0;
                ADDR_PERIOD:   period_d = writedata;
                ADDR_LENGTH: begin
                    if (writedata == 32'd0)               length_d = (AW+1)'(1);
                    else if (writedata > 32'(DEPTH))      length_d = (AW+1)'(DEPTH);
                    else                                  length_d = writedata[AW:0];
                end
                ADDR_TBL_ADDR: tbl_addr_d = writedata[AW-1:0];
                ADDR_TBL_DATA: begin
                    tbl_we     = 1'b1;
                    tbl_addr_d = tbl_addr_q + AW'(1);
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                out_d = data_d;
            end
            ST_RUN: begin
                if (ctrl_wr && !writedata[CTRL_RUN]) begin
                    state_d = ST_IDLE;
                    out_d   = data_d;
                end else if (!ctrl_wr && tmr_zero) begin
                    if (last && !ctrl_q[CTRL_LOOP]) begin
                        state_d          = ST_IDLE;
                        data_d           = tbl_q[last_idx];
                        done_d           = 1'b1;
                        ctrl_d[CTRL_RUN] = 1'b0;
                    end else begin
                        idx_d    = last ? IDX_ZERO : idx_q + AW'(1);
                        out_d    = tbl_q[idx_d];
                        tmr_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Start/restart from either state
        if (ctrl_wr && writedata[CTRL_RUN]) begin
            state_d  = ST_RUN;
            idx_d    = IDX_ZERO;
            out_d    = tbl_q[IDX_ZERO];
            done_d   = 1'b0;
            tmr_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            out_q      <= '0;
            data_q     <= '0;
            ctrl_q     <= '0;
            done_q     <= 1'b0;
            period_q   <= PERIOD_RESET;
            length_q   <= (AW+1)'(DEPTH);
            tbl_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_q      <= out_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            done_q     <= done_d;
            period_q   <= period_d;
            length_q   <= length_d;
            tbl_addr_q <= tbl_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[tbl_addr_q] <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            ADDR_DATA:     rdata[WIDTH-1:0] = data_q;
            ADDR_CONTROL:  rdata[2:0] = ctrl_q;
            ADDR_STATUS: begin
                rdata[STAT_BUSY]            = (state_q == ST_RUN);
                rdata[STAT_DONE]            = done_q;
                rdata[STAT_IDX_LSB +: 8]    = 8'(idx_q);
            end
            ADDR_PERIOD:   rdata = period_q;
            ADDR_LENGTH:   rdata[AW:0] = length_q;
            ADDR_TBL_ADDR: rdata[AW-1:0] = tbl_addr_q;
            ADDR_TBL_DATA: rdata[WIDTH-1:0] = tbl_q[tbl_addr_q];
            default: ;
        endcase
    end

    assign readdata = rdata;
    assign out_port = out_q;
    assign irq      = done_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_nios_system_led_sequencer.sv
// Randomized bench for the LED sequencer; expected LED traces are derived
// from step arithmetic (entry = cycle / (PERIOD+1)) rather than a cycle model.
module tb_nios_system_led_sequencer;

    localparam logic [2:0] A_DATA = 3'd0, A_CTRL = 3'd1, A_STAT = 3'd2, A_PER = 3'd3,
                           A_LEN = 3'd4, A_TADDR = 3'd5, A_TDATA = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [8:0]  out_port;
    logic        irq;

    logic [8:0]  tbl_m [16];
    logic [8:0]  data_m;
    int          n_vec = 0;
    int          n_err = 0;

    nios_system_led_sequencer dut (
        .clk        (clk),
        .reset      (rst),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        d = readdata;
    endtask

    task automatic prog(input int len, input int per);
        wr(A_TADDR, 32'd0);
        for (int i = 0; i < 16; i++) begin
            tbl_m[i] = 9'($urandom_range(0, 511));
            wr(A_TDATA, 32'(tbl_m[i]));
        end
        wr(A_LEN, 32'(len));
        wr(A_PER, 32'(per));
    endtask

    // Start a run and check every cycle of it: LED value, index and busy/done.
    task automatic run_seq(input bit lp, input int len, input int per, input int ncyc);
        int step, expi;
        wr(A_CTRL, lp ? 32'h3 : 32'h5);
        address = A_STAT;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            step = c / (per + 1);
            expi = lp ? (step % len) : step;
            chk("run_out", 32'(out_port), 32'(tbl_m[expi]));
            chk("run_idx", 32'(readdata[15:8]), 32'(expi));
            chk("run_busy_done", 32'(readdata[1:0]), 32'h1);
        end
    endtask

    task automatic oneshot_end(input int len);
        logic [31:0] r;
        @(negedge clk);
        chk("end_out", 32'(out_port), 32'(tbl_m[len-1]));
        chk("end_status", 32'(readdata[1:0]), 32'h2);
        chk("end_irq", 32'(irq), 32'h1);
        rd(A_DATA, r);
        chk("end_data", r, 32'(tbl_m[len-1]));
        rd(A_CTRL, r);
        chk("end_ctrl", r, 32'h4);
        data_m = tbl_m[len-1];
    endtask

    initial begin
        logic [31:0] r;
        int len, per;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        address = A_PER;  #1; chk("rst_period", readdata, 32'd49_999_999);
        address = A_LEN;  #1; chk("rst_length", readdata, 32'd16);
        address = A_CTRL; #1; chk("rst_ctrl", readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain output register behaviour
        chk("idle_pre", 32'(out_port), 32'h0);
        wr(A_DATA, 32'h1A5);
        chk("idle_out", 32'(out_port), 32'h1A5);
        rd(A_DATA, r);
        chk("idle_rd", r, 32'h1A5);
        chk("idle_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 5; i++) begin
            data_m = 9'($urandom_range(0, 511));
            wr(A_DATA, {$urandom_range(0, 8388607), data_m});
            chk("idle_rand_out", 32'(out_port), 32'(data_m));
            rd(A_DATA, r);
            chk("idle_rand_rd", r, 32'(data_m));
        end

        // LENGTH clamping
        wr(A_LEN, 32'd0);  rd(A_LEN, r); chk("len_zero", r, 32'd1);
        wr(A_LEN, 32'd20); rd(A_LEN, r); chk("len_big", r, 32'd16);
        wr(A_LEN, 32'd7);  rd(A_LEN, r); chk("len_mid", r, 32'd7);

        // Directed three-entry one-shot
        wr(A_TADDR, 32'd0);
        tbl_m[0] = 9'h001; tbl_m[1] = 9'h002; tbl_m[2] = 9'h004;
        for (int i = 0; i < 3; i++) wr(A_TDATA, 32'(tbl_m[i]));
        rd(A_TADDR, r);
        chk("taddr_inc", r, 32'd3);
        wr(A_TADDR, 32'd1);
        rd(A_TDATA, r); chk("tdata_rd", r, 32'h002);
        rd(A_TADDR, r); chk("tdata_rd_noinc", r, 32'd1);
        wr(A_LEN, 32'd3);
        wr(A_PER, 32'd4);
        run_seq(1'b0, 3, 4, 15);
        oneshot_end(3);

        // Random one-shot runs
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 16);
            per = $urandom_range(0, 3);
            prog(len, per);
            rd(A_TADDR, r);
            chk("taddr_wrap", r, 32'd0);
            run_seq(1'b0, len, per, len * (per + 1));
            oneshot_end(len);
        end

        // Random loop runs, stopped mid-step
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 6);
            per = $urandom_range(0, 2);
            prog(len, per);
            run_seq(1'b1, len, per, 2 * len * (per + 1) + $urandom_range(0, 5));
            wr(A_CTRL, 32'd0);
            chk("stop_out", 32'(out_port), 32'(data_m));
            rd(A_STAT, r);
            chk("stop_status", 32'(r[1:0]), 32'h0);
            chk("stop_irq", 32'(irq), 32'h0);
        end

        // PERIOD=0, LENGTH=0 -> single one-cycle step; set beats clear
        wr(A_PER, 32'd0);
        wr(A_LEN, 32'd0);
        rd(A_LEN, r);
        chk("len0_rd", r, 32'd1);
        wr(A_CTRL, 32'h5);
        chk("p0_out", 32'(out_port), 32'(tbl_m[0]));
        wr(A_STAT, 32'h2);
        rd(A_STAT, r);
        chk("p0_set_wins", 32'(r[1:0]), 32'h2);
        chk("p0_irq", 32'(irq), 32'h1);
        chk("p0_hold", 32'(out_port), 32'(tbl_m[0]));
        wr(A_STAT, 32'h2);
        chk("w1c_irq", 32'(irq), 32'h0);
        rd(A_STAT, r);
        chk("w1c_done", 32'(r[1:0]), 32'h0);

        // Asynchronous reset mid-run
        prog(16, 100);
        wr(A_CTRL, 32'h5);
        repeat (37) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chipselect = 1'b0;
        #1;
        chk("arst_out", 32'(out_port), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        address = A_CTRL; #1; chk("arst_ctrl", readdata, 32'd0);
        address = A_PER;  #1; chk("arst_period", readdata, 32'd49_999_999);
        address = A_LEN;  #1; chk("arst_length", readdata, 32'd16);
        address = A_STAT; #1; chk("arst_status", readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LENGTH shrunk below the current index ends at the step boundary
        prog(8, 4);
        wr(A_CTRL, 32'h5);
        repeat (16) begin @(posedge clk); #1; end
        chk("shrink_step3", 32'(out_port), 32'(tbl_m[3]));
        wr(A_LEN, 32'd2);
        chk("shrink_live", 32'(out_port), 32'(tbl_m[3]));
        repeat (3) begin @(posedge clk); #1; end
        chk("shrink_hold", 32'(out_port), 32'(tbl_m[3]));
        rd(A_STAT, r);
        chk("shrink_status", 32'(r[1:0]), 32'h2);
        rd(A_DATA, r);
        chk("shrink_data", r, 32'(tbl_m[1]));
        @(negedge clk);
        chk("shrink_idle_out", 32'(out_port), 32'(tbl_m[1]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
